// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline controller: FSM state, per-latch
// enable/flush pair, and the stage-latch fields the hazard logic consumes.
package pipeline_ctrl_pkg;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W_DEF        = 32;
    localparam int REG_ADDR_W       = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    // A flush only lands when the latch is also enabled, so BUBBLE carries en=1.
    localparam latch_ctrl_t LATCH_ADVANCE = '{en: 1'b1, flush: 1'b0};
    localparam latch_ctrl_t LATCH_HOLD    = '{en: 1'b0, flush: 1'b0};
    localparam latch_ctrl_t LATCH_BUBBLE  = '{en: 1'b1, flush: 1'b1};
    localparam latch_ctrl_t LATCH_RESET   = '{en: 1'b0, flush: 1'b1};

    typedef struct packed {
        logic                  mem_ren;
        logic                  reg_wen;
        logic [REG_ADDR_W-1:0] reg_dest;
    } idex_hazard_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
    } id_operands_t;

    typedef struct packed {
        logic mem_ren;
        logic mem_wen;
    } exmem_mem_t;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds an operand of the
// instruction in ID. Register 0 is hardwired, so it never creates a hazard.
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  idex_hazard_t ex_i,
    input  id_operands_t id_i,
    output logic         load_use_o
);

    logic dest_live;
    logic rs_match;
    logic rt_match;

    always_comb begin
        dest_live  = ex_i.mem_ren & ex_i.reg_wen & (ex_i.reg_dest != '0);
        rs_match   = (ex_i.reg_dest == id_i.rs);
        rt_match   = id_i.uses_rt & (ex_i.reg_dest == id_i.rt);
        load_use_o = dest_live & (rs_match | rt_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: per-latch enables and flushes,
// halt-drain FSM and saturating stall-cycle counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic                  ex_memren,
    input  logic                  ex_regwen,
    input  logic [REG_ADDR_W-1:0] ex_regdest,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_br_taken,
    input  logic                  id_jump,
    input  logic                  id_halt,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  halt,
    output logic [CNT_W-1:0]      stall_cnt,
    output ctrl_state_t           dbg_state_o
);

    localparam int DW = cnt_bits(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic         mem_busy;
    logic         load_use;
    logic         pc_en_c;
    latch_ctrl_t  ifid_c, idex_c, exmem_c, memwb_c;
    idex_hazard_t ex_hz;
    id_operands_t id_ops;
    exmem_mem_t   mem_acc;

    always_comb begin
        ex_hz    = '{mem_ren: ex_memren, reg_wen: ex_regwen, reg_dest: ex_regdest};
        id_ops   = '{rs: id_rs, rt: id_rt, uses_rt: id_uses_rt};
        mem_acc  = '{mem_ren: mem_ren, mem_wen: mem_wen};
        mem_busy = (mem_acc.mem_ren | mem_acc.mem_wen) & ~dhit;
    end

    pipeline_ctrl_hazard_detect u_hazard (
        .ex_i       (ex_hz),
        .id_i       (id_ops),
        .load_use_o (load_use)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Halt may only start draining when nothing of higher priority owns the cycle.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halt_d      = halt_q;
        case (state_q)
            RUN: begin
                if (!mem_busy && !ex_br_taken && !load_use && id_halt) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            HALTED: begin
                halt_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_en_c = 1'b1;
        ifid_c  = LATCH_ADVANCE;
        idex_c  = LATCH_ADVANCE;
        exmem_c = LATCH_ADVANCE;
        memwb_c = LATCH_ADVANCE;
        if (RST) begin
            pc_en_c = 1'b0;
            ifid_c  = LATCH_RESET;
            idex_c  = LATCH_RESET;
            exmem_c = LATCH_RESET;
            memwb_c = LATCH_RESET;
        end else begin
            case (state_q)
                RUN, DRAIN: begin
                    if (mem_busy) begin
                        // Freeze everything up to EX/MEM; WB gets a bubble.
                        pc_en_c = 1'b0;
                        ifid_c  = LATCH_HOLD;
                        idex_c  = LATCH_HOLD;
                        exmem_c = LATCH_HOLD;
                        memwb_c = LATCH_BUBBLE;
                    end else if (state_q == DRAIN) begin
                        pc_en_c = 1'b0;
                        ifid_c  = LATCH_BUBBLE;
                        idex_c  = LATCH_BUBBLE;
                    end else if (ex_br_taken) begin
                        ifid_c = LATCH_BUBBLE;
                        idex_c = LATCH_BUBBLE;
                    end else if (load_use) begin
                        pc_en_c = 1'b0;
                        ifid_c  = LATCH_HOLD;
                        idex_c  = LATCH_BUBBLE;
                    end else begin
                        if (id_jump) begin
                            ifid_c = LATCH_BUBBLE;
                        end else if (!ihit) begin
                            pc_en_c = 1'b0;
                            ifid_c  = LATCH_BUBBLE;
                        end
                        if (id_halt) begin
                            idex_c = LATCH_BUBBLE;
                        end
                    end
                end
                default: begin
                    pc_en_c = 1'b0;
                    ifid_c  = LATCH_HOLD;
                    idex_c  = LATCH_HOLD;
                    exmem_c = LATCH_HOLD;
                    memwb_c = LATCH_HOLD;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == RUN && !pc_en_c && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign pc_en       = pc_en_c;
    assign ifid_en     = ifid_c.en;
    assign idex_en     = idex_c.en;
    assign exmem_en    = exmem_c.en;
    assign memwb_en    = memwb_c.en;
    assign ifid_flush  = ifid_c.flush;
    assign idex_flush  = idex_c.flush;
    assign exmem_flush = exmem_c.flush;
    assign memwb_flush = memwb_c.flush;
    assign halt        = halt_q;
    assign stall_cnt   = stall_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: constant vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int DRAIN_N = 3;
    localparam int SAT_MAX = 15;

    typedef struct packed {
        logic       rst;
        logic       ihit;
        logic       dhit;
        logic       mem_ren;
        logic       mem_wen;
        logic       ex_memren;
        logic       ex_regwen;
        logic [4:0] ex_regdest;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       ex_br_taken;
        logic       id_jump;
        logic       id_halt;
    } in_t;

    // en/fl bit 3 = IF/ID ... bit 0 = MEM/WB
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] fl;
    } out_t;

    typedef struct {
        string name;
        in_t   vin;
        out_t  vexp;
    } vec_t;

    // ---------------- clock / signals ----------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, ihit, dhit, mem_ren, mem_wen, ex_memren, ex_regwen;
    logic [4:0] ex_regdest, id_rs, id_rt;
    logic id_uses_rt, ex_br_taken, id_jump, id_halt;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [31:0] stall_cnt;
    ctrl_state_t dbg_state;

    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt;
    logic [3:0] s_stall_cnt;
    ctrl_state_t s_dbg_state;

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_N), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .ex_memren(ex_memren), .ex_regwen(ex_regwen), .ex_regdest(ex_regdest),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_br_taken(ex_br_taken), .id_jump(id_jump), .id_halt(id_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .dbg_state_o(dbg_state)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_N), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .ex_memren(ex_memren), .ex_regwen(ex_regwen), .ex_regdest(ex_regdest),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_br_taken(ex_br_taken), .id_jump(id_jump), .id_halt(id_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush),
        .halt(s_halt), .stall_cnt(s_stall_cnt), .dbg_state_o(s_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_draining, m_halted;
    int   m_nonbusy;
    int   m_stalls;
    out_t last_out;
    logic last_halt;
    logic [31:0] last_stall;
    logic [3:0]  last_stall_sat;
    ctrl_state_t last_state;
    vec_t tbl[$];
    in_t  IDLE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_busy(input in_t v);
        return (v.mem_ren | v.mem_wen) & ~v.dhit;
    endfunction

    function automatic bit f_lu(input in_t v);
        if (!(v.ex_memren && v.ex_regwen) || v.ex_regdest == 5'd0) return 1'b0;
        return (v.ex_regdest == v.id_rs) || (v.id_uses_rt && v.ex_regdest == v.id_rt);
    endfunction

    // Reference outputs from the hazard rules, given the model's halt progress.
    function automatic out_t model_comb(input in_t v);
        out_t o;
        o.pc_en = 1'b1; o.en = 4'b1111; o.fl = 4'b0000;
        if (v.rst) begin
            o.pc_en = 1'b0; o.en = 4'b0000; o.fl = 4'b1111;
        end else if (m_halted) begin
            o.pc_en = 1'b0; o.en = 4'b0000; o.fl = 4'b0000;
        end else if (f_busy(v)) begin
            o.pc_en = 1'b0; o.en = 4'b0001; o.fl = 4'b0001;
        end else if (m_draining) begin
            o.pc_en = 1'b0; o.fl = 4'b1100;
        end else if (v.ex_br_taken) begin
            o.fl = 4'b1100;
        end else if (f_lu(v)) begin
            o.pc_en = 1'b0; o.en[3] = 1'b0; o.fl[2] = 1'b1;
        end else begin
            if (v.id_jump) o.fl[3] = 1'b1;
            else if (!v.ihit) begin o.pc_en = 1'b0; o.fl[3] = 1'b1; end
            if (v.id_halt) o.fl[2] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_edge(input in_t v, input out_t o);
        if (v.rst) begin
            m_draining = 0; m_halted = 0; m_nonbusy = 0; m_stalls = 0;
        end else if (m_halted) begin
        end else if (m_draining) begin
            if (!f_busy(v)) begin
                m_nonbusy++;
                if (m_nonbusy == DRAIN_N) begin m_halted = 1; m_draining = 0; end
            end
        end else begin
            if (!o.pc_en) m_stalls++;
            if (!f_busy(v) && !v.ex_br_taken && !f_lu(v) && v.id_halt) begin
                m_draining = 1; m_nonbusy = 0;
            end
        end
    endtask

    function automatic ctrl_state_t model_state();
        if (m_halted) return HALTED;
        if (m_draining) return DRAIN;
        return RUN;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input in_t v);
        RST = v.rst; ihit = v.ihit; dhit = v.dhit;
        mem_ren = v.mem_ren; mem_wen = v.mem_wen;
        ex_memren = v.ex_memren; ex_regwen = v.ex_regwen; ex_regdest = v.ex_regdest;
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
        ex_br_taken = v.ex_br_taken; id_jump = v.id_jump; id_halt = v.id_halt;
    endtask

    // One cycle: drive at negedge, sample and check mid-cycle, advance model at posedge.
    task automatic step(input in_t v);
        out_t exp_o;
        int   sat;
        @(negedge CLK);
        drive(v);
        #1;
        exp_o = model_comb(v);
        sat = (m_stalls > SAT_MAX) ? SAT_MAX : m_stalls;
        last_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};
        last_halt = halt; last_stall = stall_cnt;
        last_stall_sat = s_stall_cnt; last_state = dbg_state;
        chk("outputs", 64'(last_out), 64'(exp_o));
        chk("halt", 64'(halt), 64'(m_halted));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
        chk("stall_cnt_w4", 64'(s_stall_cnt), 64'(sat));
        chk("state", 64'(dbg_state), 64'(model_state()));
        @(posedge CLK);
        model_edge(v, exp_o);
    endtask

    task automatic do_reset();
        in_t v;
        v = IDLE; v.rst = 1'b1;
        step(v);
        step(v);
    endtask

    task automatic add(input string name, input in_t v, input logic pc,
                       input logic [3:0] en, input logic [3:0] fl);
        vec_t e;
        e.name = name; e.vin = v; e.vexp = '{pc_en: pc, en: en, fl: fl};
        tbl.push_back(e);
    endtask

    initial begin
        in_t v;
        IDLE = '0; IDLE.ihit = 1'b1; IDLE.dhit = 1'b1;

        // ---------------- vector table ----------------
        v = IDLE;                                             add("idle", v, 1, 4'b1111, 4'b0000);
        v = IDLE; v.ihit = 0;                                 add("imiss", v, 0, 4'b1111, 4'b1000);
        v = IDLE; v.ex_memren = 1; v.ex_regwen = 1; v.ex_regdest = 5; v.id_rs = 5;
                                                              add("lu_rs", v, 0, 4'b0111, 4'b0100);
        v.ex_regdest = 0; v.id_rs = 0;                        add("lu_r0", v, 1, 4'b1111, 4'b0000);
        v = IDLE; v.ex_memren = 1; v.ex_regwen = 1; v.ex_regdest = 7; v.id_rt = 7; v.id_uses_rt = 1;
                                                              add("lu_rt", v, 0, 4'b0111, 4'b0100);
        v.id_uses_rt = 0;                                     add("lu_rt_unused", v, 1, 4'b1111, 4'b0000);
        v = IDLE; v.mem_ren = 1; v.dhit = 0;                  add("dmiss", v, 0, 4'b0001, 4'b0001);
        v = IDLE; v.mem_wen = 1; v.dhit = 0; v.ex_memren = 1; v.ex_regwen = 1; v.ex_regdest = 3; v.id_rs = 3;
                                                              add("dmiss_lu", v, 0, 4'b0001, 4'b0001);
        v = IDLE; v.mem_ren = 1;                              add("dhit_ok", v, 1, 4'b1111, 4'b0000);
        v = IDLE; v.ihit = 0; v.ex_br_taken = 1; v.ex_memren = 1; v.ex_regwen = 1; v.ex_regdest = 4; v.id_rs = 4;
                                                              add("br_over_lu", v, 1, 4'b1111, 4'b1100);
        v = IDLE; v.ihit = 0; v.id_jump = 1;                  add("jump_imiss", v, 1, 4'b1111, 4'b1000);
        v = IDLE; v.rst = 1;                                  add("reset", v, 0, 4'b0000, 4'b1111);

        drive(IDLE);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        m_draining = 0; m_halted = 0; m_nonbusy = 0; m_stalls = 0;
        do_reset();
        chk("reset_halt", 64'(last_halt), 64'd0);
        chk("reset_stall", 64'(last_stall), 64'd0);

        foreach (tbl[i]) begin
            step(tbl[i].vin);
            chk(tbl[i].name, 64'(last_out), 64'(tbl[i].vexp));
        end

        // ---------------- dcache miss for 4 cycles ----------------
        do_reset();
        v = IDLE; v.mem_ren = 1; v.dhit = 0;
        for (int i = 0; i < 4; i++) begin
            step(v);
            chk("dmiss4_out", 64'(last_out), 64'(9'b0_0001_0001));
        end
        v.dhit = 1;
        step(v);
        chk("dmiss4_cnt", 64'(last_stall), 64'd4);
        chk("dmiss4_resume", 64'(last_out), 64'(9'b1_1111_0000));

        // ---------------- halt drain with 2 busy cycles ----------------
        do_reset();
        v = IDLE; v.id_halt = 1;
        step(v);
        chk("halt_entry_idex_flush", 64'(last_out.fl[2]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            v = IDLE;
            if (i == 1 || i == 2) begin v.mem_ren = 1; v.dhit = 0; end
            step(v);
            chk("drain_pc_en", 64'(last_out.pc_en), 64'd0);
            chk("drain_halt_low", 64'(last_halt), 64'd0);
            chk("drain_state", 64'(last_state), 64'(DRAIN));
        end
        step(IDLE);
        chk("halt_high", 64'(last_halt), 64'd1);
        chk("halted_out", 64'(last_out), 64'd0);
        step(IDLE);
        chk("halt_sticky", 64'(last_halt), 64'd1);

        // ---------------- halt squashed by branch ----------------
        do_reset();
        v = IDLE; v.id_halt = 1; v.ex_br_taken = 1;
        step(v);
        step(IDLE);
        chk("squash_state", 64'(last_state), 64'(RUN));
        chk("squash_halt", 64'(last_halt), 64'd0);

        // ---------------- reset mid-drain ----------------
        do_reset();
        v = IDLE; v.ihit = 0;
        step(v);
        v = IDLE; v.id_halt = 1;
        step(v);
        step(IDLE);
        chk("middrain_state", 64'(last_state), 64'(DRAIN));
        v = IDLE; v.rst = 1;
        step(v);
        step(IDLE);
        chk("rst_drain_state", 64'(last_state), 64'(RUN));
        chk("rst_drain_halt", 64'(last_halt), 64'd0);
        chk("rst_drain_stall", 64'(last_stall), 64'd0);

        // ---------------- stall counter saturation (CNT_W=4) ----------------
        do_reset();
        v = IDLE; v.ihit = 0;
        for (int i = 0; i < 20; i++) step(v);
        step(IDLE);
        chk("sat_w4", 64'(last_stall_sat), 64'd15);
        chk("sat_w32", 64'(last_stall), 64'd20);

        // ---------------- random stimulus ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v.rst         = ($urandom_range(0, 49) == 0);
            v.ihit        = ($urandom_range(0, 3) != 0);
            v.dhit        = ($urandom_range(0, 2) != 0);
            v.mem_ren     = ($urandom_range(0, 3) == 0);
            v.mem_wen     = ($urandom_range(0, 5) == 0);
            v.ex_memren   = $urandom_range(0, 1);
            v.ex_regwen   = $urandom_range(0, 1);
            v.ex_regdest  = 5'($urandom_range(0, 3));
            v.id_rs       = 5'($urandom_range(0, 3));
            v.id_rt       = 5'($urandom_range(0, 3));
            v.id_uses_rt  = $urandom_range(0, 1);
            v.ex_br_taken = ($urandom_range(0, 5) == 0);
            v.id_jump     = ($urandom_range(0, 5) == 0);
            v.id_halt     = ($urandom_range(0, 11) == 0);
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
